// File: rtl/inst_rom_loader.sv
// inst_rom_loader: framed byte-stream loader that fills instruction memory.
// Define INST_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module inst_rom_loader #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         Reset_n,
  input  logic         start,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         wr_en,
  output logic [A-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO,
    S_DATA_HI, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam logic [16:0] MAX_LEN = 17'(2**A);

`ifdef INST_LOADER_CSUM_EN
  localparam state_e TAIL = S_CSUM;
`else
  localparam state_e TAIL = S_DONE;
`endif

  state_e         state_q, state_d;
  logic [A-1:0]   cnt_q, cnt_d;
  logic [15:0]    len_q, len_d;
  logic [7:0]     lo_q, lo_d;
  logic           wr_en_q, wr_en_d;
  logic [A-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]   wr_data_q, wr_data_d;
`ifdef INST_LOADER_CSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  logic accept;
  logic hi_bad;
  logic last;

  assign in_ready = (state_q == S_LEN_LO)  ||
                    (state_q == S_LEN_HI)  ||
                    (state_q == S_DATA_LO) ||
                    (state_q == S_DATA_HI) ||
                    (state_q == S_CSUM);
  assign accept   = in_valid && in_ready;
  assign hi_bad   = (in_data >> (W - 8)) != 8'd0;
  assign last     = (16'(cnt_q) + 16'd1) == len_q;

  // Next-state, frame parsing and write generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    lo_d      = lo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef INST_LOADER_CSUM_EN
    csum_d    = csum_q;
    if (accept) csum_d = csum_q ^ in_data;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          cnt_d   = '0;
`ifdef INST_LOADER_CSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          lo_d    = in_data;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = {in_data, lo_q};
          if ({1'b0, len_d} > MAX_LEN) state_d = S_ERR;
          else if (len_d == 16'd0)     state_d = TAIL;
          else                         state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          lo_d    = in_data;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          if (hi_bad) begin
            state_d = S_ERR;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = {in_data[W-9:0], lo_q};
            cnt_d     = cnt_q + A'(1);
            state_d   = last ? TAIL : S_DATA_LO;
          end
        end
      end
`ifdef INST_LOADER_CSUM_EN
      S_CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      lo_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef INST_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      lo_q      <= lo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef INST_LOADER_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = in_ready || wr_en_q;
  assign done    = state_q == S_DONE;
  assign err     = state_q == S_ERR;

endmodule
